// File: rtl/and_bist_ctrl.sv
// Self-test engine for a bitwise AND datapath: LFSR operands, programmable result latency, pass/fail with first-error capture.
// Optional AND_BIST_ERR_CNT_EN: keep running after mismatches and count them on err_count.
module and_bist_ctrl #(
  parameter int          G_WIDTH      = 8,
  parameter int          G_ITERATIONS = 50,
  parameter int          G_LATENCY    = 0,
  parameter logic [31:0] G_SEED       = 32'hACE1_2025
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [G_WIDTH-1:0] dut_a,
  output logic [G_WIDTH-1:0] dut_b,
  input  logic [G_WIDTH-1:0] dut_c,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               fail,
  output logic [15:0]        iter_cnt,
  output logic [G_WIDTH-1:0] err_a,
  output logic [G_WIDTH-1:0] err_b,
  output logic [G_WIDTH-1:0] err_c
`ifdef AND_BIST_ERR_CNT_EN
  ,
  output logic [15:0]        err_count
`endif
);

  localparam logic [31:0] SEED      = (G_SEED == 32'd0) ? 32'd1 : G_SEED;
  localparam logic [31:0] TAPS      = 32'h8020_0003;
  localparam logic [15:0] ITER_LAST = 16'(G_ITERATIONS - 1);
  localparam logic [3:0]  WAIT_LAST = (G_LATENCY > 0) ? 4'(G_LATENCY - 1) : 4'd0;

  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_WAIT, S_CHECK, S_FINISH} state_t;

  state_t             state_q, state_d;
  logic [31:0]        lfsr_q, lfsr_d;
  logic [G_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               pass_q, pass_d, fail_q, fail_d;
  logic [15:0]        iter_q, iter_d;
  logic [G_WIDTH-1:0] err_a_q, err_a_d, err_b_q, err_b_d, err_c_q, err_c_d;
  logic [3:0]         wait_q, wait_d;
  logic               mismatch, last_iter;
`ifdef AND_BIST_ERR_CNT_EN
  logic [15:0]        err_cnt_q, err_cnt_d;
`endif

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : 32'd0);
  endfunction

  assign mismatch  = (dut_c != (a_q & b_q));
  assign last_iter = (iter_q == ITER_LAST);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    iter_d  = iter_q;
    err_a_d = err_a_q;
    err_b_d = err_b_q;
    err_c_d = err_c_q;
    wait_d  = wait_q;
`ifdef AND_BIST_ERR_CNT_EN
    err_cnt_d = err_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DRIVE;
          lfsr_d  = SEED;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          iter_d  = 16'd0;
          err_a_d = '0;
          err_b_d = '0;
          err_c_d = '0;
`ifdef AND_BIST_ERR_CNT_EN
          err_cnt_d = 16'd0;
`endif
        end
      end
      S_DRIVE: begin
        a_d     = lfsr_q[G_WIDTH-1:0];
        b_d     = lfsr_q[31:32-G_WIDTH];
        wait_d  = 4'd0;
        state_d = (G_LATENCY > 0) ? S_WAIT : S_CHECK;
      end
      S_WAIT: begin
        wait_d = wait_q + 4'd1;
        if (wait_q == WAIT_LAST) state_d = S_CHECK;
      end
      S_CHECK: begin
`ifdef AND_BIST_ERR_CNT_EN
        // Every iteration is checked; only the first mismatch is captured.
        iter_d = iter_q + 16'd1;
        lfsr_d = lfsr_step(lfsr_q);
        if (mismatch) begin
          fail_d = 1'b1;
          if (!fail_q) begin
            err_a_d = a_q;
            err_b_d = b_q;
            err_c_d = dut_c;
          end
          if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        end
        if (last_iter) begin
          pass_d  = (err_cnt_d == 16'd0);
          state_d = S_FINISH;
        end else begin
          state_d = S_DRIVE;
        end
`else
        if (mismatch) begin
          fail_d  = 1'b1;
          err_a_d = a_q;
          err_b_d = b_q;
          err_c_d = dut_c;
          state_d = S_FINISH;
        end else begin
          iter_d = iter_q + 16'd1;
          lfsr_d = lfsr_step(lfsr_q);
          if (last_iter) begin
            pass_d  = 1'b1;
            state_d = S_FINISH;
          end else begin
            state_d = S_DRIVE;
          end
        end
`endif
      end
      S_FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      iter_q  <= 16'd0;
      err_a_q <= '0;
      err_b_q <= '0;
      err_c_q <= '0;
      wait_q  <= 4'd0;
`ifdef AND_BIST_ERR_CNT_EN
      err_cnt_q <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      iter_q  <= iter_d;
      err_a_q <= err_a_d;
      err_b_q <= err_b_d;
      err_c_q <= err_c_d;
      wait_q  <= wait_d;
`ifdef AND_BIST_ERR_CNT_EN
      err_cnt_q <= err_cnt_d;
`endif
    end
  end

  assign dut_a    = a_q;
  assign dut_b    = b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign iter_cnt = iter_q;
  assign err_a    = err_a_q;
  assign err_b    = err_b_q;
  assign err_c    = err_c_q;
`ifdef AND_BIST_ERR_CNT_EN
  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_and_bist_ctrl.sv
// Directed bench: three BIST instances (latency 0 with injectable faults, latency 2 and 1 against a 2-stage registered AND).
module tb_and_bist_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start0, start1, start2;
  logic [7:0] a0, b0, c0, a1, b1, c1, a2, b2, c2;
  logic       busy0, done0, pass0, fail0, busy1, done1, pass1, fail1, busy2, done2, pass2, fail2;
  logic [15:0] iter0, iter1, iter2;
  logic [7:0] ea0, eb0, ec0, ea1, eb1, ec1, ea2, eb2, ec2;
`ifdef AND_BIST_ERR_CNT_EN
  logic [15:0] cnt0, cnt1, cnt2;
  localparam int U1_ITER = 50;
  localparam int U1_LAT  = 151;
`else
  localparam int U1_ITER = 0;
  localparam int U1_LAT  = 4;
`endif

  int mode;   // 0 golden, 1 c[3] stuck-at-0, 2 invert on iterations 5 and 17
  int total = 0;
  int bad   = 0;
  int cyc;

  always_comb begin
    c0 = a0 & b0;
    if (mode == 1) c0[3] = 1'b0;
    if (mode == 2 && (iter0 == 16'd5 || iter0 == 16'd17)) c0 = ~(a0 & b0);
  end

  logic [7:0] p1s1, p1s2, p2s1, p2s2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1s1 <= '0; p1s2 <= '0; p2s1 <= '0; p2s2 <= '0;
    end else begin
      p1s1 <= a1 & b1; p1s2 <= p1s1;
      p2s1 <= a2 & b2; p2s2 <= p2s1;
    end
  end
  assign c1 = p1s2;
  assign c2 = p2s2;

  and_bist_ctrl #(.G_WIDTH(8), .G_ITERATIONS(50), .G_LATENCY(0), .G_SEED(32'hACE1_2025)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .dut_a(a0), .dut_b(b0), .dut_c(c0),
    .busy(busy0), .done(done0), .pass(pass0), .fail(fail0), .iter_cnt(iter0),
    .err_a(ea0), .err_b(eb0), .err_c(ec0)
`ifdef AND_BIST_ERR_CNT_EN
    , .err_count(cnt0)
`endif
  );
  and_bist_ctrl #(.G_WIDTH(8), .G_ITERATIONS(50), .G_LATENCY(1), .G_SEED(32'hACE1_2025)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .dut_a(a1), .dut_b(b1), .dut_c(c1),
    .busy(busy1), .done(done1), .pass(pass1), .fail(fail1), .iter_cnt(iter1),
    .err_a(ea1), .err_b(eb1), .err_c(ec1)
`ifdef AND_BIST_ERR_CNT_EN
    , .err_count(cnt1)
`endif
  );
  and_bist_ctrl #(.G_WIDTH(8), .G_ITERATIONS(50), .G_LATENCY(2), .G_SEED(32'hACE1_2025)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .dut_a(a2), .dut_b(b2), .dut_c(c2),
    .busy(busy2), .done(done2), .pass(pass2), .fail(fail2), .iter_cnt(iter2),
    .err_a(ea2), .err_b(eb2), .err_c(ec2)
`ifdef AND_BIST_ERR_CNT_EN
    , .err_count(cnt2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sel_done(input int which);
    case (which)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  task automatic pulse(input int which);
    case (which)
      0:       start0 = 1'b1;
      1:       start1 = 1'b1;
      default: start2 = 1'b1;
    endcase
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_done(input int which);
    while (!sel_done(which) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0; mode = 0; cyc = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_pass_fail", {pass0, fail0}, 2'b00);
    chk("rst_iter", iter0, 16'd0);
    chk("rst_ab", {a0, b0}, 16'h0000);
    chk("rst_err", {ea0, eb0, ec0}, 24'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Golden DUT, latency 0: operand sequence and full passing run.
    pulse(0);
    chk("t1_busy", busy0, 1'b1);
    @(negedge clk); cyc++;
    chk("t1_it0_ab", {a0, b0}, 16'h25AC);
    repeat (2) begin @(negedge clk); cyc++; end
    chk("t1_it1_ab", {a0, b0}, 16'h11D6);
    wait_done(0);
    chk("t1_latency", cyc, 101);
    chk("t1_pass_fail", {pass0, fail0}, 2'b10);
    chk("t1_iter", iter0, 16'd50);
    chk("t1_busy_end", busy0, 1'b0);
    @(negedge clk);
    chk("t1_done_sticky", {done0, busy0}, 2'b10);

    // start held high for the whole run, including the FINISH cycle.
    start0 = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (!done0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    start0 = 1'b0;
    chk("t5_latency", cyc, 101);
    chk("t5_iter", iter0, 16'd50);
    chk("t5_pass", pass0, 1'b1);
    @(negedge clk);
    chk("t5_finish_start_ignored", {busy0, done0}, 2'b01);

    // Reset in the middle of a run, then restart from the seed.
    pulse(0);
    while (iter0 != 16'd20 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("t4_midrun", {busy0, iter0}, {1'b1, 16'd20});
    rst_n = 1'b0;
    #1;
    chk("t4_async_busy_done", {busy0, done0, pass0, fail0}, 4'b0000);
    chk("t4_async_iter", iter0, 16'd0);
    chk("t4_async_ab", {a0, b0}, 16'h0000);
    chk("t4_async_err", {ea0, eb0, ec0}, 24'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse(0);
    @(negedge clk); cyc++;
    chk("t4_restart_ab", {a0, b0}, 16'h25AC);
    wait_done(0);
    chk("t4_latency", cyc, 101);
    chk("t4_pass", {pass0, fail0}, 2'b10);

`ifdef AND_BIST_ERR_CNT_EN
    // Inverted result on iterations 5 and 17; run continues to the end.
    mode = 2;
    pulse(0);
    wait_done(0);
    chk("t6_latency", cyc, 101);
    chk("t6_iter", iter0, 16'd50);
    chk("t6_err_count", cnt0, 16'd2);
    chk("t6_pass_fail", {pass0, fail0}, 2'b01);
    chk("t6_err_ab", {ea0, eb0}, 16'h02BD);
    chk("t6_err_c", ec0, 8'hFF);
`else
    // c[3] stuck at 0: iteration 2 (a=0B, b=EB) is the first with AND bit 3 set.
    mode = 1;
    pulse(0);
    wait_done(0);
    chk("t2_latency", cyc, 7);
    chk("t2_pass_fail", {pass0, fail0}, 2'b01);
    chk("t2_iter", iter0, 16'd2);
    chk("t2_err_ab", {ea0, eb0}, 16'h0BEB);
    chk("t2_err_c", ec0, 8'h03);
`endif
    mode = 0;

    // Two-stage registered AND with matching latency.
    pulse(2);
    wait_done(2);
    chk("t3a_latency", cyc, 201);
    chk("t3a_pass_fail", {pass2, fail2}, 2'b10);
    chk("t3a_iter", iter2, 16'd50);

    // Same DUT checked one cycle too early: stale result on iteration 0.
    pulse(1);
    wait_done(1);
    chk("t3b_latency", cyc, U1_LAT);
    chk("t3b_pass_fail", {pass1, fail1}, 2'b01);
    chk("t3b_iter", iter1, 16'(U1_ITER));
    chk("t3b_err_ab", {ea1, eb1}, 16'h25AC);
    chk("t3b_err_c", ec1, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
